// File: rtl/i2c_target_regfile.sv
// I2C target exposing an NREGS x 8-bit register file behind a 16-bit auto-incrementing pointer.
// Optional build macro I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
module i2c_target_regfile #(
  parameter logic [6:0]  DEV_ADDR = 7'h36,
  parameter int unsigned NREGS    = 16
) (
  input  logic        CLK_50,
  input  logic        RESET_N,
  input  logic        I2C_SCL,
  inout  wire         I2C_SDA,
  output logic        WR_STROBE,
  output logic [15:0] WR_ADDR,
  output logic [7:0]  WR_DATA,
  output logic        BUSY
);

  localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned PW = 16;
  localparam int unsigned CW = 4;

  typedef enum logic [3:0] {
    IDLE, DEVADDR, ACK_DEV, ADDR_HI, ACK_AH, ADDR_LO, ACK_AL,
    WDATA, ACK_WD, RDATA, MACK, WAIT_STOP
  } state_t;

  state_t          state, state_d;
  logic [1:0]      scl_sync, sda_sync;
  logic            scl_f, sda_f, scl_prev, sda_prev;
  logic [CW-1:0]   bit_cnt, bit_cnt_d;
  logic [7:0]      shift, shift_d, tx, tx_d;
  logic [PW-1:0]   ptr, ptr_d;
  logic            mack, mack_d;
  logic            sda_oe, sda_oe_d;
  logic            wr_strobe, wr_strobe_d;
  logic [PW-1:0]   wr_addr, wr_addr_d;
  logic [7:0]      wr_data, wr_data_d;
  logic            busy, busy_d;
  logic            we_c;
  logic [7:0]      regs [NREGS];

  // Two-flop synchronizers; reset to the idle-high bus level so no edge is seen at reset release
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], I2C_SCL};
      sda_sync <= {sda_sync[0], I2C_SDA};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] scl_win, sda_win;

  // Majority vote over the last three synchronized samples
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_win <= 3'b111;
      sda_win <= 3'b111;
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
    end else begin
      scl_win <= {scl_win[1:0], scl_sync[1]};
      sda_win <= {sda_win[1:0], sda_sync[1]};
      scl_f   <= (scl_win[0] & scl_win[1]) | (scl_win[0] & scl_win[2]) | (scl_win[1] & scl_win[2]);
      sda_f   <= (sda_win[0] & sda_win[1]) | (sda_win[0] & sda_win[2]) | (sda_win[1] & sda_win[2]);
    end
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_f;
      sda_prev <= sda_f;
    end
  end

  logic start_c, stop_c, scl_rise_c, scl_fall_c, byte_done_c, match_c;
  logic in_range_c, nxt_in_range_c;
  logic [PW-1:0] ptr_inc_c;
  logic [7:0]    rd_cur_c, rd_nxt_c;

  assign start_c     = scl_f & scl_prev & sda_prev & ~sda_f;
  assign stop_c      = scl_f & scl_prev & ~sda_prev & sda_f;
  assign scl_rise_c  = scl_f & ~scl_prev;
  assign scl_fall_c  = ~scl_f & scl_prev;
  assign byte_done_c = (bit_cnt == CW'(8));
  assign match_c     = (shift[7:1] == DEV_ADDR);
  assign ptr_inc_c   = ptr + PW'(1);
  assign in_range_c     = ((ptr >> AW) == PW'(0));
  assign nxt_in_range_c = ((ptr_inc_c >> AW) == PW'(0));
  assign rd_cur_c    = in_range_c     ? regs[ptr[AW-1:0]]       : 8'h00;
  assign rd_nxt_c    = nxt_in_range_c ? regs[ptr_inc_c[AW-1:0]] : 8'h00;

  // State register
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_d;
  end

  // Next state: STOP beats START, both beat bit-level progress
  always_comb begin
    state_d = state;
    if (stop_c) begin
      state_d = IDLE;
    end else if (start_c) begin
      state_d = DEVADDR;
    end else if (scl_fall_c) begin
      case (state)
        DEVADDR: if (byte_done_c) state_d = match_c ? ACK_DEV : WAIT_STOP;
        ACK_DEV: state_d = shift[0] ? RDATA : ADDR_HI;
        ADDR_HI: if (byte_done_c) state_d = ACK_AH;
        ACK_AH:  state_d = ADDR_LO;
        ADDR_LO: if (byte_done_c) state_d = ACK_AL;
        ACK_AL:  state_d = WDATA;
        WDATA:   if (byte_done_c) state_d = ACK_WD;
        ACK_WD:  state_d = WDATA;
        RDATA:   if (byte_done_c) state_d = MACK;
        MACK:    state_d = mack ? WAIT_STOP : RDATA;
        default: state_d = state;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    bit_cnt_d   = bit_cnt;
    shift_d     = shift;
    tx_d        = tx;
    ptr_d       = ptr;
    mack_d      = mack;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr;
    wr_data_d   = wr_data;
    busy_d      = busy;
    we_c        = 1'b0;
    if (stop_c) begin
      bit_cnt_d = '0;
      busy_d    = 1'b0;
    end else if (start_c) begin
      bit_cnt_d = '0;
    end else if (scl_rise_c) begin
      case (state)
        DEVADDR, ADDR_HI, ADDR_LO, WDATA: begin
          if (!byte_done_c) begin
            shift_d   = {shift[6:0], sda_f};
            bit_cnt_d = bit_cnt + CW'(1);
          end
        end
        RDATA:   if (!byte_done_c) bit_cnt_d = bit_cnt + CW'(1);
        MACK:    mack_d = sda_f;
        default: ;
      endcase
    end else if (scl_fall_c) begin
      case (state)
        DEVADDR: if (byte_done_c && match_c) busy_d = 1'b1;
        ADDR_HI: if (byte_done_c) ptr_d[15:8] = shift;
        ADDR_LO: if (byte_done_c) ptr_d[7:0]  = shift;
        WDATA: begin
          if (byte_done_c) begin
            we_c        = in_range_c;
            wr_strobe_d = 1'b1;
            wr_addr_d   = ptr;
            wr_data_d   = shift;
          end
        end
        ACK_DEV: begin
          bit_cnt_d = '0;
          tx_d      = rd_cur_c;
        end
        ACK_AH, ACK_AL: bit_cnt_d = '0;
        ACK_WD: begin
          bit_cnt_d = '0;
          ptr_d     = ptr_inc_c;
        end
        RDATA: if (!byte_done_c) tx_d = {tx[6:0], 1'b0};
        MACK: begin
          if (!mack) begin
            bit_cnt_d = '0;
            ptr_d     = ptr_inc_c;
            tx_d      = rd_nxt_c;
          end
        end
        default: ;
      endcase
    end
    case (state_d)
      ACK_DEV, ACK_AH, ACK_AL, ACK_WD: sda_oe_d = 1'b1;
      RDATA:                           sda_oe_d = ~tx_d[7];
      default:                         sda_oe_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      bit_cnt   <= '0;
      shift     <= '0;
      tx        <= '0;
      ptr       <= '0;
      mack      <= 1'b1;
      sda_oe    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
    end else begin
      bit_cnt   <= bit_cnt_d;
      shift     <= shift_d;
      tx        <= tx_d;
      ptr       <= ptr_d;
      mack      <= mack_d;
      sda_oe    <= sda_oe_d;
      wr_strobe <= wr_strobe_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
      busy      <= busy_d;
    end
  end

  // Register file; out-of-range pointers never write
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (we_c) begin
      regs[ptr[AW-1:0]] <= shift;
    end
  end

  assign I2C_SDA   = sda_oe ? 1'b0 : 1'bz;
  assign WR_STROBE = wr_strobe;
  assign WR_ADDR   = wr_addr;
  assign WR_DATA   = wr_data;
  assign BUSY      = busy;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: bit-banged I2C initiator with a pulled-up SDA line.
module tb_i2c_target_regfile;

  localparam int Q = 10;

  logic        clk;
  logic        rst_n;
  logic        scl;
  logic        sda_drv;
  wire         sda;
  logic        wr_strobe;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int strobes  = 0;

  assign sda = sda_drv ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_target_regfile dut (
    .CLK_50    (clk),
    .RESET_N   (rst_n),
    .I2C_SCL   (scl),
    .I2C_SDA   (sda),
    .WR_STROBE (wr_strobe),
    .WR_ADDR   (wr_addr),
    .WR_DATA   (wr_data),
    .BUSY      (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) if (wr_strobe) strobes++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b0; wait_cyc(Q);
    scl = 1'b1;     wait_cyc(Q);
    sda_drv = 1'b1; wait_cyc(Q);
    scl = 1'b0;     wait_cyc(Q);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b1; wait_cyc(Q);
    scl = 1'b1;     wait_cyc(Q);
    sda_drv = 1'b0; wait_cyc(Q);
  endtask

  task automatic send_bit(input logic b);
    wait_cyc(Q);
    sda_drv = ~b;
    wait_cyc(Q);
    scl = 1'b1;
    wait_cyc(2*Q);
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    wait_cyc(Q); sda_drv = 1'b0;
    wait_cyc(Q); scl = 1'b1;
    wait_cyc(Q); ack = sda;
    wait_cyc(Q); scl = 1'b0;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    sda_drv = 1'b0;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      wait_cyc(2*Q); scl = 1'b1;
      wait_cyc(Q);   d = {d[6:0], sda};
      wait_cyc(Q);   scl = 1'b0;
    end
    wait_cyc(Q); sda_drv = ~nack;
    wait_cyc(Q); scl = 1'b1;
    wait_cyc(2*Q); scl = 1'b0;
    wait_cyc(Q); sda_drv = 1'b0;
  endtask

  task automatic wr_reg(input string tag, input logic [15:0] a, input logic [7:0] d);
    logic ack;
    i2c_start();
    send_byte(8'h6C, ack);   check({tag, "_ack_dev"}, 32'(ack), 32'd0);
    send_byte(a[15:8], ack); check({tag, "_ack_ah"},  32'(ack), 32'd0);
    send_byte(a[7:0], ack);  check({tag, "_ack_al"},  32'(ack), 32'd0);
    send_byte(d, ack);       check({tag, "_ack_wd"},  32'(ack), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    i2c_stop();
  endtask

  task automatic rd_reg(input string tag, input logic [15:0] a, output logic [7:0] d);
    logic ack;
    i2c_start();
    send_byte(8'h6C, ack);   check({tag, "_ack_dev"}, 32'(ack), 32'd0);
    send_byte(a[15:8], ack);
    send_byte(a[7:0], ack);
    i2c_start();
    send_byte(8'h6D, ack);   check({tag, "_ack_rd"},  32'(ack), 32'd0);
    recv_byte(1'b1, d);
    i2c_stop();
  endtask

  initial begin
    logic       ack;
    logic [7:0] d0, d1;
    rst_n = 1'b0; scl = 1'b1; sda_drv = 1'b0;
    wait_cyc(5);
    check("rst_strobe", 32'(wr_strobe), 32'd0);
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_addr",   32'(wr_addr),   32'd0);
    check("rst_data",   32'(wr_data),   32'd0);
    check("rst_sda",    32'(sda),       32'd1);
    rst_n = 1'b1;
    wait_cyc(5);

    // Single write of 0xA5 to register 3
    wr_reg("w3", 16'h0003, 8'hA5);
    wait_cyc(5);
    check("w3_strobes", 32'(strobes), 32'd1);
    check("w3_addr",    32'(wr_addr), 32'h0003);
    check("w3_data",    32'(wr_data), 32'hA5);
    check("w3_busy_off",32'(busy),    32'd0);

    wr_reg("w4", 16'h0004, 8'h3C);
    wait_cyc(5);
    check("w4_strobes", 32'(strobes), 32'd2);
    check("w4_data",    32'(wr_data), 32'h3C);

    // Random read of two bytes starting at 3, ACK then NACK
    i2c_start();
    send_byte(8'h6C, ack); check("rd_ack_dev", 32'(ack), 32'd0);
    send_byte(8'h00, ack); check("rd_ack_ah",  32'(ack), 32'd0);
    send_byte(8'h03, ack); check("rd_ack_al",  32'(ack), 32'd0);
    i2c_start();
    send_byte(8'h6D, ack); check("rd_ack_rd",  32'(ack), 32'd0);
    recv_byte(1'b0, d0);   check("rd_byte0",   32'(d0),  32'hA5);
    recv_byte(1'b1, d1);   check("rd_byte1",   32'(d1),  32'h3C);
    wait_cyc(Q);
    check("rd_sda_rel", 32'(sda), 32'd1);
    i2c_stop();
    wait_cyc(5);
    check("rd_no_strobe", 32'(strobes), 32'd2);

    // Address mismatch
    i2c_start();
    send_byte(8'h50, ack); check("mm_nack", 32'(ack),  32'd1);
    check("mm_busy", 32'(busy), 32'd0);
    i2c_stop();
    wait_cyc(5);
    check("mm_strobes", 32'(strobes), 32'd2);

    // Out-of-range write and read
    wr_reg("oor", 16'h0020, 8'h77);
    wait_cyc(5);
    check("oor_strobes", 32'(strobes), 32'd3);
    check("oor_addr",    32'(wr_addr), 32'h0020);
    check("oor_data",    32'(wr_data), 32'h77);
    rd_reg("oor_rd", 16'h0020, d0); check("oor_rd_val", 32'(d0), 32'h00);
    rd_reg("r0", 16'h0000, d0);     check("r0_val",     32'(d0), 32'h00);
    rd_reg("r3", 16'h0003, d0);     check("r3_val",     32'(d0), 32'hA5);

    // STOP after four data bits
    i2c_start();
    send_byte(8'h6C, ack);
    send_byte(8'h00, ack);
    send_byte(8'h05, ack);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    i2c_stop();
    wait_cyc(5);
    check("mid_strobes", 32'(strobes), 32'd3);
    check("mid_busy",    32'(busy),    32'd0);
    check("mid_sda",     32'(sda),     32'd1);
    rd_reg("r5", 16'h0005, d0); check("r5_val", 32'(d0), 32'h00);

    // Reset while the target drives bit 6 (0) of 0xA5
    i2c_start();
    send_byte(8'h6C, ack);
    send_byte(8'h00, ack);
    send_byte(8'h03, ack);
    i2c_start();
    send_byte(8'h6D, ack);
    wait_cyc(2*Q); scl = 1'b1;
    wait_cyc(2*Q); scl = 1'b0;
    wait_cyc(Q);
    check("rst_mid_drive0", 32'(sda), 32'd0);
    rst_n = 1'b0;
    wait_cyc(1);
    check("rst_mid_sda",    32'(sda),       32'd1);
    check("rst_mid_strobe", 32'(wr_strobe), 32'd0);
    check("rst_mid_busy",   32'(busy),      32'd0);
    check("rst_mid_addr",   32'(wr_addr),   32'd0);
    check("rst_mid_data",   32'(wr_data),   32'd0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(3);
    i2c_stop();
    rd_reg("r3_post", 16'h0003, d0); check("r3_post_val", 32'(d0), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
